// File: rtl/io_dev_pkg.sv
// Shared types and helpers for the I/O device blocks.
package io_dev_pkg;

  // Binary-to-BCD converter control states.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } b2b_state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Largest value representable in n decimal digits (10^n - 1).
  // Valid for n up to 19; beyond that the 64-bit result wraps.
  function automatic logic [63:0] pow10_minus1(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3
  import io_dev_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Inputs are legal BCD (0..9), so the result never exceeds 12.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Values above 10^N_DIG - 1 saturate to all nines and set ovf.
module bin2bcd_seq
  import io_dev_pkg::*;
#(
  parameter int unsigned IN_W  = 27,
  parameter int unsigned N_DIG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   bin_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [4*N_DIG-1:0] bcd_out
);

  localparam int unsigned BCD_W = 4 * N_DIG;
  localparam int unsigned SR_W  = BCD_W + IN_W;
  // Comparison width must hold both MAX_VAL and the largest input.
  localparam int unsigned CMP_W = (IN_W > 64) ? IN_W : 64;
  localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [CMP_W-1:0] MAX_VAL  = CMP_W'(pow10_minus1(N_DIG));
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W - 1);

  b2b_state_t       state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  bcd_digit_t       adj_dig [N_DIG];

  // One add-3 corrector per BCD digit of the working register.
  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (sr[IN_W + 4*i +: 4]),
      .dout (adj_dig[i])
    );
  end

  // Corrected register: BCD digits replaced, binary field untouched.
  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      sr_adj[IN_W + 4*i +: 4] = adj_dig[i];
    end
  end

  // Control FSM with registered outputs and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= SR_W'(bin_in);
            cnt      <= CNT_INIT;
            ovf_pend <= (CMP_W'(bin_in) > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr <= {sr_adj[SR_W-2:0], 1'b0};
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          bcd_out <= ovf_pend ? {N_DIG{4'h9}} : sr[SR_W-1:IN_W];
          ovf     <= ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, reset abort,
// held-start throughput and randomized conversions against a decimal model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [26:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [31:0] bcd_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done = -1;
  int min_gap = 1000;

  bin2bcd_seq #(.IN_W(27), .N_DIG(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Track done pulses and the shortest spacing between them.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (last_done >= 0 && (cyc - last_done) < min_gap) min_gap = cyc - last_done;
      last_done = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal digit extraction with saturation.
  task automatic ref_conv(input logic [26:0] val, output logic [31:0] bcd, output logic o);
    longint unsigned v;
    longint unsigned p;
    v = val;
    bcd = '0;
    o = 1'b0;
    if (v > 64'd99999999) begin
      bcd = 32'h99999999;
      o = 1'b1;
    end else begin
      p = 1;
      for (int d = 0; d < 8; d++) begin
        bcd[4*d +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
    end
  endtask

  // Issue one conversion from IDLE; report result, done latency and busy length.
  task automatic run_conv(input logic [26:0] val, output logic [31:0] bcd,
                          output logic o, output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1;
    bin_in = val;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin_in = 27'($urandom_range(0, 134217727));
    lat = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    bcd = bcd_out;
    o = ovf;
  endtask

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        o;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r_bcd;
    logic [31:0] e_bcd;
    logic        r_o;
    logic        e_o;
    int          lat;
    int          bcyc;
    int          dc0;
    logic [26:0] vals[0:99];
    logic [26:0] v;

    vecs[0] = '{27'd0,         32'h00000000, 1'b0};
    vecs[1] = '{27'd12345678,  32'h12345678, 1'b0};
    vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
    vecs[3] = '{27'd100000000, 32'h99999999, 1'b1};
    vecs[4] = '{27'd134217727, 32'h99999999, 1'b1};
    vecs[5] = '{27'd5,         32'h00000005, 1'b0};
    vecs[6] = '{27'd9,         32'h00000009, 1'b0};
    vecs[7] = '{27'd10,        32'h00000010, 1'b0};
    vecs[8] = '{27'd1000,      32'h00001000, 1'b0};
    vecs[9] = '{27'd90000009,  32'h90000009, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_bcd", bcd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, r_bcd, r_o, lat, bcyc);
      chk("tbl_bcd", r_bcd, vecs[i].bcd);
      chk("tbl_ovf", r_o, vecs[i].o);
      chk("tbl_latency", lat, 28);
      chk("tbl_busy_cycles", bcyc, 28);
      chk("tbl_busy_at_done", busy, 0);
    end

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    start = 1'b1;
    bin_in = 27'd12345678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    dc0 = done_count;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_bcd", bcd_out, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", done_count, dc0);
    run_conv(27'd42, r_bcd, r_o, lat, bcyc);
    chk("after_abort_bcd", r_bcd, 32'h00000042);
    chk("after_abort_ovf", r_o, 0);
    chk("after_abort_latency", lat, 28);

    // Start held high while bin_in changes every cycle.
    for (int n = 0; n < 87; n++) begin
      @(negedge clk);
      start = 1'b1;
      bin_in = 27'($urandom_range(0, 134217727));
      vals[n] = bin_in;
      @(posedge clk);
      #1;
      chk("held_done", done, ((n % 29) == 28) ? 1 : 0);
      if ((n % 29) == 28) begin
        ref_conv(vals[n - 28], e_bcd, e_o);
        chk("held_bcd", bcd_out, e_bcd);
        chk("held_ovf", ovf, e_o);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized conversions with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (i % 4 == 0) v = 27'($urandom_range(99990000, 100010000));
      else v = 27'($urandom_range(0, 134217727));
      run_conv(v, r_bcd, r_o, lat, bcyc);
      ref_conv(v, e_bcd, e_o);
      chk("rand_bcd", r_bcd, e_bcd);
      chk("rand_ovf", r_o, e_o);
      chk("rand_latency", lat, 28);
    end

    chk("done_min_gap_ok", (min_gap >= 29) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment display driver. It takes an unsigned binary value from the CPU I/O register path and converts it to `N_DIG` packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. Its one-cycle `done` pulse drives the display driver's `en` input, and `bcd_out` drives its `digits` input. Values too large for `N_DIG` digits saturate to all nines and raise a flag.

## Interface
- `IN_W`, default 27: width of the binary input. Must be at least 1.
- `N_DIG`, default 8: number of BCD digits. Output width is `4*N_DIG`.
- `clk`  in  1: system clock. All state is updated on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: conversion request. Sampled only in IDLE.
- `bin_in`  in  `IN_W`: unsigned value. Sampled on the same edge that accepts `start`.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd_out` and `ovf` update. Connects to the display driver's `en`.
- `ovf`  out  1: input exceeded `10^N_DIG - 1`. Updates together with `done` and holds until the next `done`.
- `bcd_out`  out  `4*N_DIG`: packed BCD. Digit 0 is bits [3:0]. Holds its value between conversions.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `ovf`=0, `bcd_out`=0; shift register and counter are 0.
- Local constant `MAX_VAL` = `10^N_DIG - 1`. Its width must hold both `MAX_VAL` and `2^IN_W - 1`.
- Working shift register is `4*N_DIG + IN_W` bits: the BCD field on top, the binary field below it.
- FSM states: IDLE, SHIFT, FINISH.
  - **IDLE**: if `start`=1, load `bin_in` into the binary field and clear the BCD field. Set the bit counter to `IN_W - 1`. Latch `ovf_pend` = (`bin_in` > `MAX_VAL`). Set `busy`=1 and go to SHIFT. If `start`=0, stay in IDLE.
  - **SHIFT**: each cycle, add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1. When the counter reaches 0, go to FINISH; otherwise decrement it.
  - **FINISH**: load `bcd_out` with the BCD field, or with all 9s if `ovf_pend`. Set `ovf` = `ovf_pend`, pulse `done`=1, clear `busy`, return to IDLE.
- A conversion always runs all `IN_W` iterations, overflow or not, so latency is constant.
- `start` while `busy`=1 is ignored and not queued. Changes to `bin_in` after capture do not affect the result.
- `rst_n` low mid-conversion aborts immediately. Outputs return to their reset values and no `done` is issued.
- No arithmetic carries out of a nibble. After add-3 each nibble is at most 12, and after the shift every nibble holds a legal BCD digit.

## Timing
- Edge E0 accepts `start`. `busy` is high from after E0 until E(`IN_W`+1): `IN_W`+1 cycles, 28 at the default.
- Edges E1..E(`IN_W`) perform the iterations.
- E(`IN_W`+1) updates `bcd_out`/`ovf` and raises `done`. `done` falls at the next edge.
- The earliest next accepted `start` is at E(`IN_W`+2), including a `start` held high during the `done` cycle. Throughput is one conversion per `IN_W`+2 cycles (29 at the default).
- `bcd_out` and `ovf` are stable whenever `done`=1. Both are registered with no combinational path from the inputs.

## Structure
- Shared package `io_dev_pkg` holds:
  - state enum `b2b_state_t` {IDLE, SHIFT, FINISH};
  - `typedef logic [3:0] bcd_digit_t`.
- Combinational sub-module `bcd_add3` (4-bit in, 4-bit out: add 3 if >= 5), instantiated `N_DIG` times in a generate loop.
- `MAX_VAL` is a parameter-derived localparam in the module, not in the package.

## Test plan
- Reset: assert `rst_n`=0 ten cycles after accepting `bin_in`=12345678 -> all outputs 0, no `done` pulse; after release, IDLE accepts a new `start`.
- `bin_in`=0 -> `bcd_out`=0x00000000, `ovf`=0; `done` exactly 28 edges after the accept edge.
- `bin_in`=12345678 -> `bcd_out`=0x12345678, `ovf`=0; `busy` high exactly 28 cycles.
- Boundaries:
  - `bin_in`=99999999 -> 0x99999999, `ovf`=0;
  - 100000000 -> 0x99999999, `ovf`=1;
  - 134217727 -> 0x99999999, `ovf`=1;
  - a following `bin_in`=5 -> 0x00000005, `ovf`=0.
- `start` held high with `bin_in` changing every cycle -> `done` pulses every 29 cycles; each result matches the value present on the accept edge only.
- 1000 random `bin_in` values below 2^27 at random start gaps -> results match a reference model's decimal conversion/saturation; `done` never pulses twice within 29 cycles.
